// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the pipelined ALU: operating modes, function select
// codes for each mode, and the controller state encoding.
// No ports; imported by alu_pipe and alu_mul_iter.
// ---------------------------------------------------------------------------
package alu_pkg;

   typedef enum logic [1:0] {
      MODE_LOGIC = 2'b00,
      MODE_ARITH = 2'b01,
      MODE_SHIFT = 2'b10,
      MODE_MUL   = 2'b11
   } mode_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      HOLD = 2'd2
   } state_t;

   // Logic mode selects
   localparam logic [3:0] SEL_L_NOTA       = 4'h0;
   localparam logic [3:0] SEL_L_NOR        = 4'h1;
   localparam logic [3:0] SEL_L_NOTA_AND_B = 4'h2;
   localparam logic [3:0] SEL_L_ZERO       = 4'h3;
   localparam logic [3:0] SEL_L_NAND       = 4'h4;
   localparam logic [3:0] SEL_L_NOTB       = 4'h5;
   localparam logic [3:0] SEL_L_XOR        = 4'h6;
   localparam logic [3:0] SEL_L_A_AND_NOTB = 4'h7;
   localparam logic [3:0] SEL_L_NOTA_OR_B  = 4'h8;
   localparam logic [3:0] SEL_L_XNOR       = 4'h9;
   localparam logic [3:0] SEL_L_B          = 4'hA;
   localparam logic [3:0] SEL_L_AND        = 4'hB;
   localparam logic [3:0] SEL_L_ONES       = 4'hC;
   localparam logic [3:0] SEL_L_A_OR_NOTB  = 4'hD;
   localparam logic [3:0] SEL_L_OR         = 4'hE;
   localparam logic [3:0] SEL_L_A          = 4'hF;

   // Arithmetic mode selects
   localparam logic [3:0] SEL_A_ADD = 4'h0;
   localparam logic [3:0] SEL_A_SUB = 4'h1;
   localparam logic [3:0] SEL_A_INC = 4'h2;
   localparam logic [3:0] SEL_A_DEC = 4'h3;

   // Shift mode selects
   localparam logic [3:0] SEL_S_SLL = 4'h0;
   localparam logic [3:0] SEL_S_SRL = 4'h1;
   localparam logic [3:0] SEL_S_SRA = 4'h2;
   localparam logic [3:0] SEL_S_ROL = 4'h3;

   // Multiply mode selects
   localparam logic [3:0] SEL_M_LO = 4'h0;
   localparam logic [3:0] SEL_M_HI = 4'h1;

endpackage

// File: rtl/alu_mul_iter.sv
// ---------------------------------------------------------------------------
// alu_mul_iter
// Unsigned iterative shift-add multiplier, one multiplier bit per cycle.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   i_start        load operands; bit 0 of i_b is consumed on this edge
//   i_a, i_b       multiplicand / multiplier (WIDTH bits)
//   o_done         high during the cycle in which o_product is final
//   o_product      full 2*WIDTH-bit product
// ---------------------------------------------------------------------------
module alu_mul_iter
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_start,
   input  logic [WIDTH-1:0]   i_a,
   input  logic [WIDTH-1:0]   i_b,
   output logic               o_done,
   output logic [2*WIDTH-1:0] o_product
);

   localparam int CW = $clog2(WIDTH) + 1;

   logic [2*WIDTH-1:0] r_acc;
   logic [2*WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0]   r_mplier;
   logic [CW-1:0]      r_count;
   logic               r_running;

   // The start edge already folds in multiplier bit 0, so WIDTH-1 further
   // steps finish the product. Done is flagged while the final value sits in
   // the accumulator so the owner can capture it on the next edge, giving
   // WIDTH edges of work in total between start and capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc     <= '0;
         r_mcand   <= '0;
         r_mplier  <= '0;
         r_count   <= '0;
         r_running <= 1'b0;
      end else if (i_start) begin
         r_acc     <= i_b[0] ? {{WIDTH{1'b0}}, i_a} : '0;
         r_mcand   <= {{(WIDTH-1){1'b0}}, i_a, 1'b0};
         r_mplier  <= {1'b0, i_b[WIDTH-1:1]};
         r_count   <= CW'(1);
         r_running <= 1'b1;
      end else if (o_done) begin
         r_running <= 1'b0;
      end else if (r_running) begin
         if (r_mplier[0]) begin
            r_acc <= r_acc + r_mcand;
         end
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_count  <= r_count + CW'(1);
      end
   end

   assign o_done    = r_running && (r_count == CW'(WIDTH));
   assign o_product = r_acc;

endmodule

// File: rtl/alu_pipe.sv
// ---------------------------------------------------------------------------
// alu_pipe
// Registered ALU with valid/ready handshakes on both sides: logic,
// arithmetic, barrel shift and an iterative multiply.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid / in_ready    operation handshake (operands captured on accept)
//   mode, select, carry_in operation code and carry/borrow input
//   in_a, in_b             operands
//   out_valid / out_ready  result handshake
//   alu_out, carry_out     result and carry/borrow/shifted-out bit
//   compare                in_a == in_b of the operation being reported
//   zero, negative, overflow  result flags
//   busy                   multiplier running
// ---------------------------------------------------------------------------
module alu_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       mode,
   input  logic [3:0]       select,
   input  logic             carry_in,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] alu_out,
   output logic             carry_out,
   output logic             compare,
   output logic             zero,
   output logic             negative,
   output logic             overflow,
   output logic             busy
);

   localparam int M = WIDTH - 1;

   state_t             r_state, w_stateNext;
   logic [WIDTH-1:0]   r_aluOut;
   logic               r_carry, r_compare, r_zero, r_negative, r_overflow;
   logic               r_mulHi, r_cmpPend;

   logic               w_accept, w_isMul, w_mulDone;
   logic [2*WIDTH-1:0] w_mulProd;
   logic [WIDTH-1:0]   w_mulRes, w_opB, w_rol, w_result;
   logic [WIDTH:0]     w_addExt, w_subExt, w_shlExt, w_shrExt, w_sraExt;
   logic [SHW-1:0]     w_amt;
   logic [SHW:0]       w_rolBack;
   logic               w_addOvf, w_subOvf, w_carry, w_overflow;

   assign w_isMul  = (mode_t'(mode) == MODE_MUL);
   assign in_ready = (r_state == IDLE) || ((r_state == HOLD) && out_ready);
   assign w_accept = in_valid && in_ready;

   alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_start   (w_accept && w_isMul),
      .i_a       (in_a),
      .i_b       (in_b),
      .o_done    (w_mulDone),
      .o_product (w_mulProd)
   );

   // Increment/decrement reuse the add/sub paths with B forced to zero, so
   // carry, borrow and overflow come out of the same expressions.
   assign w_opB    = ((select == SEL_A_INC) || (select == SEL_A_DEC)) ? '0 : in_b;
   assign w_addExt = {1'b0, in_a} + {1'b0, w_opB} + {{WIDTH{1'b0}}, carry_in};
   assign w_subExt = {1'b0, in_a} - {1'b0, w_opB} - {{WIDTH{1'b0}}, carry_in};
   assign w_addOvf = (in_a[M] == w_opB[M]) && (w_addExt[M] != in_a[M]);
   assign w_subOvf = (in_a[M] != w_opB[M]) && (w_subExt[M] != in_a[M]);

   // Shifts run one bit wider than the operand so the last bit shifted out
   // lands in the extra position; a zero amount leaves a zero there.
   assign w_amt     = in_b[SHW-1:0];
   assign w_shlExt  = {1'b0, in_a} << w_amt;
   assign w_shrExt  = {in_a, 1'b0} >> w_amt;
   assign w_sraExt  = $signed({in_a, 1'b0}) >>> w_amt;
   assign w_rolBack = (SHW+1)'(WIDTH) - {1'b0, w_amt};
   assign w_rol     = (in_a << w_amt) | (in_a >> w_rolBack);

   assign w_mulRes = r_mulHi ? w_mulProd[2*WIDTH-1:WIDTH] : w_mulProd[WIDTH-1:0];

   // Function-unit select for single-cycle ops. Reserved arithmetic and
   // shift selects fall through to the zero defaults.
   always_comb begin
      w_result   = '0;
      w_carry    = 1'b0;
      w_overflow = 1'b0;
      case (mode_t'(mode))
         MODE_LOGIC: begin
            case (select)
               SEL_L_NOTA:       w_result = ~in_a;
               SEL_L_NOR:        w_result = ~(in_a | in_b);
               SEL_L_NOTA_AND_B: w_result = ~in_a & in_b;
               SEL_L_ZERO:       w_result = '0;
               SEL_L_NAND:       w_result = ~(in_a & in_b);
               SEL_L_NOTB:       w_result = ~in_b;
               SEL_L_XOR:        w_result = in_a ^ in_b;
               SEL_L_A_AND_NOTB: w_result = in_a & ~in_b;
               SEL_L_NOTA_OR_B:  w_result = ~in_a | in_b;
               SEL_L_XNOR:       w_result = ~(in_a ^ in_b);
               SEL_L_B:          w_result = in_b;
               SEL_L_AND:        w_result = in_a & in_b;
               SEL_L_ONES:       w_result = '1;
               SEL_L_A_OR_NOTB:  w_result = in_a | ~in_b;
               SEL_L_OR:         w_result = in_a | in_b;
               default:          w_result = in_a;
            endcase
         end
         MODE_ARITH: begin
            case (select)
               SEL_A_ADD, SEL_A_INC: begin
                  w_result   = w_addExt[WIDTH-1:0];
                  w_carry    = w_addExt[WIDTH];
                  w_overflow = w_addOvf;
               end
               SEL_A_SUB, SEL_A_DEC: begin
                  w_result   = w_subExt[WIDTH-1:0];
                  w_carry    = w_subExt[WIDTH];
                  w_overflow = w_subOvf;
               end
               default: ;
            endcase
         end
         MODE_SHIFT: begin
            case (select)
               SEL_S_SLL: begin
                  w_result = w_shlExt[WIDTH-1:0];
                  w_carry  = w_shlExt[WIDTH];
               end
               SEL_S_SRL: begin
                  w_result = w_shrExt[WIDTH:1];
                  w_carry  = w_shrExt[0];
               end
               SEL_S_SRA: begin
                  w_result = w_sraExt[WIDTH:1];
                  w_carry  = w_sraExt[0];
               end
               SEL_S_ROL: w_result = w_rol;
               default: ;
            endcase
         end
         default: ;
      endcase
   end

   // Controller: single-cycle ops go straight to HOLD, multiplies sit in
   // MUL until the iterator finishes. A consumer taking the result can
   // hand over the next operation in the same cycle.
   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         IDLE: if (w_accept) w_stateNext = w_isMul ? MUL : HOLD;
         MUL:  if (w_mulDone) w_stateNext = HOLD;
         HOLD: begin
            if (w_accept)       w_stateNext = w_isMul ? MUL : HOLD;
            else if (out_ready) w_stateNext = IDLE;
         end
         default: w_stateNext = IDLE;
      endcase
   end

   // Result and flag registers. A multiply remembers its half-select and
   // operand equality at acceptance, and publishes them only when the
   // product is ready so every output describes the same operation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_aluOut   <= '0;
         r_carry    <= 1'b0;
         r_compare  <= 1'b0;
         r_zero     <= 1'b0;
         r_negative <= 1'b0;
         r_overflow <= 1'b0;
         r_mulHi    <= 1'b0;
         r_cmpPend  <= 1'b0;
      end else begin
         r_state <= w_stateNext;
         if (w_accept && !w_isMul) begin
            r_aluOut   <= w_result;
            r_carry    <= w_carry;
            r_overflow <= w_overflow;
            r_zero     <= (w_result == '0);
            r_negative <= w_result[M];
            r_compare  <= (in_a == in_b);
         end else if (w_mulDone) begin
            r_aluOut   <= w_mulRes;
            r_carry    <= |w_mulProd[2*WIDTH-1:WIDTH];
            r_overflow <= 1'b0;
            r_zero     <= (w_mulRes == '0);
            r_negative <= w_mulRes[M];
            r_compare  <= r_cmpPend;
         end
         if (w_accept && w_isMul) begin
            r_mulHi   <= (select == SEL_M_HI);
            r_cmpPend <= (in_a == in_b);
         end
      end
   end

   assign out_valid = (r_state == HOLD);
   assign busy      = (r_state == MUL);
   assign alu_out   = r_aluOut;
   assign carry_out = r_carry;
   assign compare   = r_compare;
   assign zero      = r_zero;
   assign negative  = r_negative;
   assign overflow  = r_overflow;

endmodule

// File: tb/tb_alu_pipe.sv
// ---------------------------------------------------------------------------
// tb_alu_pipe
// Directed-vector bench for alu_pipe (WIDTH=16) with hand-computed results.
// ---------------------------------------------------------------------------
module tb_alu_pipe;

   logic        clk = 1'b0;
   logic        rst_n, in_valid, in_ready, carry_in, out_valid, out_ready;
   logic [1:0]  mode;
   logic [3:0]  select;
   logic [15:0] in_a, in_b, alu_out;
   logic        carry_out, compare, zero, negative, overflow, busy;

   int checkCount = 0;
   int errorCount = 0;
   int busyCycles;
   logic sawValid;

   always #5 clk = ~clk;

   alu_pipe dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mode      (mode),
      .select    (select),
      .carry_in  (carry_in),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .alu_out   (alu_out),
      .carry_out (carry_out),
      .compare   (compare),
      .zero      (zero),
      .negative  (negative),
      .overflow  (overflow),
      .busy      (busy)
   );

   // Single comparison point: counts the check and reports any difference.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
      end
   endtask

   // Presents one operation with in_valid raised.
   task automatic applyStimulus(input logic [1:0] m, input logic [3:0] s,
                                input logic c, input logic [15:0] a,
                                input logic [15:0] b);
      mode     = m;
      select   = s;
      carry_in = c;
      in_a     = a;
      in_b     = b;
      in_valid = 1'b1;
   endtask

   // Advance one cycle and settle just after the rising edge.
   task automatic stepClock();
      @(posedge clk);
      #1;
   endtask

   // Result-side check of value, carry and the four other flags.
   task automatic checkResult(input string tag, input logic [15:0] res,
                              input logic c, input logic z, input logic n,
                              input logic v);
      checkOutput({tag, ".valid"}, 32'(out_valid), 32'h1);
      checkOutput({tag, ".out"},   32'(alu_out),   32'(res));
      checkOutput({tag, ".carry"}, 32'(carry_out), 32'(c));
      checkOutput({tag, ".zero"},  32'(zero),      32'(z));
      checkOutput({tag, ".neg"},   32'(negative),  32'(n));
      checkOutput({tag, ".ovf"},   32'(overflow),  32'(v));
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      mode = 2'b00; select = 4'h0; carry_in = 1'b0; in_a = '0; in_b = '0;
      #1 rst_n = 1'b0;
      #2;
      checkOutput("rst.inReady",  32'(in_ready),  32'h1);
      checkOutput("rst.outValid", 32'(out_valid), 32'h0);
      checkOutput("rst.busy",     32'(busy),      32'h0);
      checkOutput("rst.out",      32'(alu_out),   32'h0);
      checkOutput("rst.zero",     32'(zero),      32'h0);
      stepClock();
      stepClock();
      rst_n = 1'b1;
      checkOutput("postRst.inReady", 32'(in_ready), 32'h1);

      // Back-to-back single-cycle ops with out_ready held high
      applyStimulus(2'b01, 4'h0, 1'b0, 16'hFFFF, 16'h0001); stepClock();
      checkResult("addWrap", 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
      applyStimulus(2'b01, 4'h1, 1'b0, 16'h8000, 16'h0001); stepClock();
      checkResult("subOvf", 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus(2'b01, 4'h1, 1'b1, 16'h0001, 16'h0001); stepClock();
      checkResult("subBorrow", 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0);
      applyStimulus(2'b01, 4'h2, 1'b1, 16'h7FFF, 16'h1234); stepClock();
      checkResult("incOvf", 16'h8000, 1'b0, 1'b0, 1'b1, 1'b1);
      applyStimulus(2'b01, 4'h5, 1'b1, 16'h1234, 16'h0000); stepClock();
      checkResult("arithRsvd", 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(2'b00, 4'h6, 1'b0, 16'h1234, 16'h1234); stepClock();
      checkResult("xorEq", 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("xorEq.cmp", 32'(compare), 32'h1);
      applyStimulus(2'b00, 4'hD, 1'b0, 16'h00F0, 16'hFF0F); stepClock();
      checkResult("aOrNotB", 16'h00F0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("aOrNotB.cmp", 32'(compare), 32'h0);
      applyStimulus(2'b10, 4'h2, 1'b0, 16'h8001, 16'h0004); stepClock();
      checkResult("sra4", 16'hF800, 1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus(2'b10, 4'h0, 1'b0, 16'h8001, 16'h0001); stepClock();
      checkResult("sll1", 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(2'b10, 4'h3, 1'b0, 16'h8001, 16'h0004); stepClock();
      checkResult("rol4", 16'h0018, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(2'b10, 4'h1, 1'b0, 16'h0003, 16'h0001); stepClock();
      checkResult("srl1", 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(2'b10, 4'h1, 1'b0, 16'h8001, 16'h0000); stepClock();
      checkResult("srl0", 16'h8001, 1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus(2'b10, 4'h0, 1'b0, 16'h0001, 16'h0014); stepClock();
      checkResult("sllAmtMask", 16'h0010, 1'b0, 1'b0, 1'b0, 1'b0);
      in_valid = 1'b0; stepClock();
      checkOutput("drain.outValid", 32'(out_valid), 32'h0);

      // Multiply high half, with an op pulsed while busy
      applyStimulus(2'b11, 4'h1, 1'b0, 16'hFFFF, 16'hFFFF); stepClock();
      in_valid = 1'b0;
      busyCycles = 0;
      while (busy && busyCycles < 40) begin
         busyCycles++;
         if (busyCycles == 3) begin
            applyStimulus(2'b00, 4'hF, 1'b0, 16'hAAAA, 16'h5555);
            checkOutput("mul.inReadyBusy", 32'(in_ready), 32'h0);
         end else begin
            in_valid = 1'b0;
         end
         stepClock();
      end
      in_valid = 1'b0;
      checkOutput("mul.busyCycles", 32'(busyCycles), 32'd16);
      checkResult("mulHi", 16'hFFFE, 1'b1, 1'b0, 1'b1, 1'b0);
      checkOutput("mulHi.cmp", 32'(compare), 32'h1);
      stepClock();
      checkOutput("mulDrain.outValid", 32'(out_valid), 32'h0);

      // Output stall, then release with the next op waiting
      out_ready = 1'b0;
      applyStimulus(2'b00, 4'hE, 1'b0, 16'h00F0, 16'h0F00); stepClock();
      checkResult("or", 16'h0FF0, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(2'b01, 4'h0, 1'b0, 16'h0001, 16'h0001);
      for (int i = 0; i < 5; i++) begin
         checkOutput("stall.inReady", 32'(in_ready),  32'h0);
         checkOutput("stall.out",     32'(alu_out),   32'h0FF0);
         checkOutput("stall.valid",   32'(out_valid), 32'h1);
         stepClock();
      end
      out_ready = 1'b1;
      #1;
      checkOutput("release.inReady", 32'(in_ready), 32'h1);
      stepClock();
      in_valid = 1'b0;
      checkResult("releaseAdd", 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("releaseAdd.cmp", 32'(compare), 32'h1);
      stepClock();

      // Reset in the middle of a multiply
      applyStimulus(2'b11, 4'h0, 1'b0, 16'h0003, 16'h0005); stepClock();
      in_valid = 1'b0;
      repeat (6) stepClock();
      checkOutput("midMul.busy", 32'(busy), 32'h1);
      rst_n = 1'b0;
      #1;
      checkOutput("midRst.out",      32'(alu_out),   32'h0);
      checkOutput("midRst.busy",     32'(busy),      32'h0);
      checkOutput("midRst.inReady",  32'(in_ready),  32'h1);
      checkOutput("midRst.outValid", 32'(out_valid), 32'h0);
      checkOutput("midRst.cmp",      32'(compare),   32'h0);
      stepClock();
      rst_n = 1'b1;
      sawValid = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (out_valid) sawValid = 1'b1;
         stepClock();
      end
      checkOutput("midRst.noResult", 32'(sawValid), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, registered successor to the team's combinational 16-bit ALU. It adds a valid/ready handshake on input and output, a registered flag set, a barrel-shift mode, and a multi-cycle iterative multiplier. It sits between the operand-fetch stage and the writeback stage of the datapath and is the ALU all new cores instantiate.

## Interface
- WIDTH, default 16: operand and result width; at least 4, power of two.
- SHW, default $clog2(WIDTH): width of the shift amount taken from in_b.
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  operation presented.
- in_ready  out  1  block accepts an operation this cycle.
- mode  in  2  00 logic, 01 arithmetic, 10 shift, 11 multiply.
- select  in  4  function within the mode.
- carry_in  in  1  carry or borrow input.
- in_a, in_b  in  WIDTH  operands.
- out_valid  out  1  result registers hold an unconsumed result.
- out_ready  in  1  consumer takes the result.
- alu_out  out  WIDTH  result.
- carry_out  out  1  carry, borrow or last bit shifted out.
- compare  out  1  in_a == in_b, captured at acceptance.
- zero, negative, overflow  out  1 each  registered flags.
- busy  out  1  multiplier running.

## Operation
- An operation is accepted on in_valid && in_ready. Operands, mode and select are captured on that edge; later input changes have no effect.
- **Logic mode**, select 0..F: ~A, ~(A|B), ~A&B, 0, ~(A&B), ~B, A^B, A&~B, ~A|B, ~(A^B), B, A&B, all-ones, A|~B, A|B, A. carry_out=0, overflow=0.
- **Arithmetic mode**, computed at WIDTH+1 bits:
  - select 0: A+B+cin.
  - select 1: A-B-cin.
  - select 2: A+cin.
  - select 3: A-cin.
  - Add: carry_out is bit WIDTH. Subtract: carry_out is the borrow, 1 iff A < B+cin unsigned.
  - overflow: signed overflow of the add or subtract.
  - select 4..F: result 0, all flags 0 except zero=1.
- **Shift mode**, amount = in_b[SHW-1:0]:
  - select 0 SLL, 1 SRL, 2 SRA, 3 ROL.
  - carry_out is the last bit shifted out; 0 when the amount is 0 or the op is ROL.
  - select 4..F behave as reserved arithmetic selects.
- **Multiply mode**, unsigned shift-add over WIDTH iterations:
  - select 0: low WIDTH bits of the product.
  - select 1: high WIDTH bits of the product.
  - carry_out = 1 iff the high half is nonzero.
  - Other selects behave as select 0.
- **Flags** (all modes): zero = (alu_out == 0); negative = alu_out[WIDTH-1].
- **FSM**:
  - IDLE → HOLD on accepting a non-multiply op.
  - IDLE → MUL on accepting a multiply.
  - MUL → HOLD after WIDTH iterations.
  - HOLD → IDLE on out_ready with no new accept.
  - HOLD → HOLD when out_ready and a new single-cycle op are accepted in the same cycle.
  - HOLD → MUL when out_ready and a multiply are accepted in the same cycle.
- in_ready = (state==IDLE) || (state==HOLD && out_ready).
- out_valid = (state==HOLD). busy = (state==MUL).

## Timing
- Reset: state IDLE. alu_out, carry_out, compare, flags, out_valid and busy are all 0. in_ready=1 during and after reset.
- Single-cycle ops: accepted at edge N, out_valid=1 after edge N. Back-to-back throughput is 1 per cycle when out_ready is held at 1.
- Multiply: accepted at edge N, busy for edges N+1..N+WIDTH, out_valid after edge N+WIDTH. Latency is WIDTH+1 cycles.
- Stall: while out_valid && !out_ready, all outputs hold stable and in_ready=0.
- in_valid while busy: not accepted, because in_ready=0.
- rst_n asserted mid-multiply or in HOLD: immediate return to reset values; the pending result is discarded.
- Flags and compare always update together with alu_out and refer to the same operation.

## Structure
- Package alu_pkg holds:
  - the mode enum: MODE_LOGIC, MODE_ARITH, MODE_SHIFT, MODE_MUL;
  - the select localparams per mode;
  - the FSM state typedef: IDLE, MUL, HOLD.
- One sub-module, alu_mul_iter: start/done interface, WIDTH-parameterised shift-add multiplier with iteration counter. The top contains the combinational function units, the FSM and the result/flag registers.

## Test plan
- Reset, then mode=01 sel=0, A=FFFF, B=0001, cin=0, out_ready=1 → one cycle later alu_out=0000, carry=1, zero=1, overflow=0.
- mode=01 sel=1, A=8000, B=0001, cin=0 → alu_out=7FFF, carry=0, overflow=1, negative=0.
- mode=10 sel=2, A=8001, B=0004 → alu_out=F800, carry=0. Then sel=0, A=8001, B=0001 → alu_out=0002, carry=1.
- mode=11 sel=1, A=FFFF, B=FFFF → busy for 16 cycles, then out_valid with alu_out=FFFE, carry=1. in_valid pulsed during busy is ignored.
- out_ready=0 for 5 cycles after a logic op (A=00F0, B=0F00, sel=E → 0FF0) → outputs stable, in_ready=0. Raising out_ready with in_valid high accepts the next op in that same cycle.
- Assert rst_n low at busy cycle 7 of a multiply → all outputs 0 immediately, in_ready=1, and no out_valid after release.
